// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output.
// Flags stop-bit framing errors and overruns.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          done_ok;
    logic          done_bad;

    assign s       = sync[1];
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            done_ok     <= 1'b0;
            done_bad    <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_in};
            done_ok     <= 1'b0;
            done_bad    <= 1'b0;
            frame_error <= done_bad;
            overrun     <= 1'b0;

            // Stop-sample result is applied one edge later on the outputs
            if (done_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt        <= '0;
                        shreg[idx] <= s;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (s) begin
                            done_ok <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            done_bad <= 1'b1;
                            state    <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes
// compared against a bit-timing model of an 8N1 line.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int LAT = 3 + N / 2 + 9 * N;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       rx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    // Host-side observer: edge numbering, pulses and consumed bytes
    int edge_no = 0;
    int rise_edge = -1, fall_edge = -1, fe_edge = -1, ov_edge = -1;
    int rises = 0, falls = 0, fe_cnt = 0, ov_cnt = 0;
    int both_cnt = 0, wide_cnt = 0, unstable = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        logic       v0, r0, fe0, ov0;
        logic [7:0] d0;
        edge_no++;
        v0  = rx_valid;
        r0  = rx_ready;
        d0  = rx_data;
        fe0 = frame_error;
        ov0 = overrun;
        #1;
        if (!reset) begin
            if (v0 && r0) got_q.push_back(d0);
            if (!v0 && rx_valid) begin rises++; rise_edge = edge_no; end
            if (v0 && !rx_valid) begin falls++; fall_edge = edge_no; end
            if (frame_error) begin
                fe_cnt++; fe_edge = edge_no;
                if (fe0) wide_cnt++;
            end
            if (overrun) begin
                ov_cnt++; ov_edge = edge_no;
                if (ov0) wide_cnt++;
            end
            if (frame_error && overrun) both_cnt++;
            if (v0 && !r0 && rx_valid && rx_data != d0) unstable++;
        end
    end

    // Line driver; entered and left right after a falling clock edge
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int hold, output int t0);
        rx_in = 1'b0;
        t0 = edge_no + 1;
        repeat (N) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_in = d[k];
            repeat (N) @(negedge clk);
        end
        rx_in = stop;
        repeat (N + hold) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        int r0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rx_data, rx_valid, frame_error, overrun, rx_busy} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_in: got %h/%b/%b/%b/%b want 00/0/0/0/0",
                     rx_data, rx_valid, frame_error, overrun, rx_busy);
        end
        reset = 1'b0;
        r0 = rises;
        repeat (100) @(negedge clk);
        n_cmp++;
        if ({rx_data, rx_valid, frame_error, overrun, rx_busy} !== 12'h0
            || rises != r0 || fe_cnt != 0 || ov_cnt != 0) begin
            n_bad++;
            $display("FAIL reset_idle: got %h/%b/%b/%b/%b want 00/0/0/0/0",
                     rx_data, rx_valid, frame_error, overrun, rx_busy);
        end
    endtask

    task automatic test_basic();
        int t0, rdy_edge;
        rx_ready = 1'b0;
        got_q.delete();
        send_frame(8'hA5, 1'b1, 0, t0);
        n_cmp++;
        if (rise_edge != t0 + LAT) begin
            n_bad++;
            $display("FAIL a5_rise: got edge %0d want %0d", rise_edge - t0, LAT);
        end
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL a5_data: got %b/%h want 1/a5", rx_valid, rx_data);
        end
        repeat (5) @(negedge clk);
        rdy_edge = edge_no + 1;
        consume();
        n_cmp++;
        if (rx_valid !== 1'b0 || fall_edge != rdy_edge) begin
            n_bad++;
            $display("FAIL a5_fall: got valid %b at edge %0d want 0 at %0d",
                     rx_valid, fall_edge, rdy_edge);
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL a5_read: got %0d bytes want one a5", got_q.size());
        end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = rises;
        f0 = fe_cnt;
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy: got %b want 1", rx_busy);
        end
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rises != r0 || fe_cnt != f0) begin
            n_bad++;
            $display("FAIL glitch_abort: got busy %b valid %b fe %0d want 0/0/%0d",
                     rx_busy, rx_valid, fe_cnt, f0);
        end
    endtask

    task automatic test_frame_error();
        int t0, r0, f0;
        r0 = rises;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 40, t0);
        n_cmp++;
        if (fe_cnt != f0 + 1 || fe_edge != t0 + LAT) begin
            n_bad++;
            $display("FAIL fe_pulse: got %0d pulses at %0d want 1 at %0d",
                     fe_cnt - f0, fe_edge - t0, LAT);
        end
        n_cmp++;
        if (rx_valid !== 1'b0 || rises != r0 || rx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fe_hold: got valid %b busy %b want 0/1", rx_valid, rx_busy);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fe_release: got busy %b want 0", rx_busy);
        end
        send_frame(8'h55, 1'b1, 0, t0);
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55 || rise_edge != t0 + LAT) begin
            n_bad++;
            $display("FAIL fe_next: got %b/%h want 1/55", rx_valid, rx_data);
        end
        consume();
    endtask

    task automatic test_overrun();
        int ta, tb, o0;
        got_q.delete();
        o0 = ov_cnt;
        send_frame(8'h11, 1'b1, 0, ta);
        send_frame(8'h22, 1'b1, 0, tb);
        n_cmp++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_keep: got %b/%h want 1/11", rx_valid, rx_data);
        end
        n_cmp++;
        if (ov_cnt != o0 + 1 || ov_edge != tb + LAT) begin
            n_bad++;
            $display("FAIL ovr_pulse: got %0d at %0d want 1 at %0d",
                     ov_cnt - o0, ov_edge - tb, LAT);
        end
        consume();
        got_q.delete();
        o0 = ov_cnt;
        send_frame(8'h11, 1'b1, 0, ta);
        fork
            send_frame(8'h22, 1'b1, 0, tb);
            begin
                repeat (LAT - 1) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        n_cmp++;
        if (rx_data !== 8'h22 || rx_valid !== 1'b1 || ov_cnt != o0) begin
            n_bad++;
            $display("FAIL ovr_ready: got %b/%h ovr %0d want 1/22 0",
                     rx_valid, rx_data, ov_cnt - o0);
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'h11) begin
            n_bad++;
            $display("FAIL ovr_read: got %0d bytes want one 11", got_q.size());
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int t0, r0, f0;
        r0 = rises;
        f0 = fe_cnt;
        rx_in = 1'b0;
        repeat (N) @(negedge clk);
        rx_in = 1'b1;
        repeat (4 * N + N / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (120) @(negedge clk);
        n_cmp++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rises != r0 || fe_cnt != f0) begin
            n_bad++;
            $display("FAIL rst_abort: got busy %b valid %b want 0/0", rx_busy, rx_valid);
        end
        send_frame(8'h81, 1'b1, 0, t0);
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81 || rise_edge != t0 + LAT) begin
            n_bad++;
            $display("FAIL rst_next: got %b/%h want 1/81", rx_valid, rx_data);
        end
        consume();
    endtask

    task automatic test_random();
        int t0, o0, f0;
        logic [7:0] d;
        logic [7:0] got;
        got_q.delete();
        o0 = ov_cnt;
        f0 = fe_cnt;
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 0, t0);
            got = (got_q.size() > 0) ? got_q.pop_front() : ~d;
            n_cmp++;
            if (got !== d || rise_edge != t0 + LAT) begin
                n_bad++;
                $display("FAIL rand_byte%0d: got %h at %0d want %h at %0d",
                         i, got, rise_edge - t0, d, LAT);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_ready = 1'b0;
        n_cmp++;
        if (ov_cnt != o0 || fe_cnt != f0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_flags: got ovr %0d fe %0d extra %0d want 0/0/0",
                     ov_cnt - o0, fe_cnt - f0, got_q.size());
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (both_cnt != 0 || wide_cnt != 0) begin
            n_bad++;
            $display("FAIL pulse_shape: got both %0d wide %0d want 0/0", both_cnt, wide_cnt);
        end
        n_cmp++;
        if (unstable != 0) begin
            n_bad++;
            $display("FAIL data_stable: got %0d changes want 0", unstable);
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        rx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
